signal_shaper: RTL

Upstream conditioning stage for the hit counter. It synchronises the asynchronous discriminator output into the clk domain and detects edges with selectable polarity. Each accepted hit becomes one clean pulse of programmable width, followed by a programmable dead time. The shaped pulse drives the counter's signal input. The block is gated by the counter's dwrite flag and counts hits rejected during dead time.

---
 rtl/signal_shaper.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/signal_shaper.sv
// signal_shaper: discriminator synchroniser, polarity-selectable edge detect,
// programmable pulse/dead-time shaper with saturating rejected-hit counter.
module signal_shaper #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int REJ_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [7:0]            addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  we,
    input  logic                  signal_in,
    input  logic                  gate,
    output logic                  pulse_out,
    output logic                  dead_active,
    output logic                  rej_sat
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_DEAD
    } state_t;

    localparam logic [7:0] A_DEAD_LO = 8'h36;
    localparam logic [7:0] A_DEAD_HI = 8'h37;
    localparam logic [7:0] A_PW      = 8'h38;
    localparam logic [7:0] A_CTRL    = 8'h39;
    localparam logic [7:0] A_REJ_LO  = 8'h3A;
    localparam logic [7:0] A_REJ_HI  = 8'h3B;

    localparam logic [REJ_WIDTH-1:0] REJ_MAX = '1;
    localparam logic [REJ_WIDTH-1:0] REJ_ONE = {{(REJ_WIDTH-1){1'b0}}, 1'b1};

    logic [15:0]            r_dead;
    logic [7:0]             r_pw;
    logic                   r_inv;
    logic [REJ_WIDTH-1:0]   r_rej;
    logic                   r_rej_sat;
    logic [DATA_WIDTH-1:0]  r_data_out;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_gate_d;
    state_t                 r_state;
    logic [15:0]            r_cnt;
    logic [15:0]            r_dead_lat;
    logic                   r_pulse;
    logic                   r_dead_act;

    logic [7:0]             w_wdata;
    logic [7:0]             w_rdata;
    logic [15:0]            w_rej16;
    logic                   w_s;
    logic                   w_edge;
    logic                   w_gate_rise;
    logic [15:0]            w_pw_m1;
    logic [REJ_WIDTH-1:0]   w_rej_p1;
    state_t                 w_state_nxt;
    logic [15:0]            w_cnt_nxt;
    logic                   w_hit;
    logic                   w_rej_inc;

    assign w_wdata     = data_in[7:0];
    assign w_rej16     = 16'(r_rej);
    assign w_s         = signal_in ^ r_inv;
    assign w_edge      = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign w_gate_rise = gate & ~r_gate_d;
    assign w_pw_m1     = (r_pw == 8'd0) ? 16'd0 : {8'd0, r_pw - 8'd1};
    assign w_rej_p1    = r_rej + REJ_ONE;

    assign data_out    = r_data_out;
    assign pulse_out   = r_pulse;
    assign dead_active = r_dead_act;
    assign rej_sat     = r_rej_sat;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_dead <= 16'h0010;
            r_pw   <= 8'h02;
            r_inv  <= 1'b0;
        end else if (we) begin
            case (addr)
                A_DEAD_LO: r_dead[7:0]  <= w_wdata;
                A_DEAD_HI: r_dead[15:8] <= w_wdata;
                A_PW:      r_pw         <= w_wdata;
                A_CTRL:    r_inv        <= w_wdata[0];
                default:   ;
            endcase
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (addr)
            A_DEAD_LO: w_rdata = r_dead[7:0];
            A_DEAD_HI: w_rdata = r_dead[15:8];
            A_PW:      w_rdata = r_pw;
            A_CTRL:    w_rdata = {7'd0, r_inv};
            A_REJ_LO:  w_rdata = w_rej16[7:0];
            A_REJ_HI:  w_rdata = w_rej16[15:8];
            default:   w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_data_out <= '0;
        end else begin
            r_data_out <= DATA_WIDTH'(w_rdata);
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_sync   <= '0;
            r_hist   <= 1'b0;
            r_gate_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], w_s};
            r_hist   <= r_sync[SYNC_STAGES-1];
            r_gate_d <= gate;
        end
    end

    // Dead time is latched at the hit so a mid-pulse write waits for the next hit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hit       = 1'b0;
        w_rej_inc   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_edge && gate) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = w_pw_m1;
                    w_hit       = 1'b1;
                end
            end
            S_PULSE: begin
                w_rej_inc = w_edge & gate;
                if (r_cnt == 16'd0) begin
                    if (r_dead_lat != 16'd0) begin
                        w_state_nxt = S_DEAD;
                        w_cnt_nxt   = r_dead_lat - 16'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_DEAD: begin
                w_rej_inc = w_edge & gate;
                if (r_cnt == 16'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_dead_lat <= 16'd0;
            r_pulse    <= 1'b0;
            r_dead_act <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pulse    <= (w_state_nxt == S_PULSE);
            r_dead_act <= (w_state_nxt != S_IDLE);
            if (w_hit) begin
                r_dead_lat <= r_dead;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_rej     <= '0;
            r_rej_sat <= 1'b0;
        end else if (w_gate_rise) begin
            r_rej     <= '0;
            r_rej_sat <= 1'b0;
        end else if (w_rej_inc && (r_rej != REJ_MAX)) begin
            r_rej <= w_rej_p1;
            if (w_rej_p1 == REJ_MAX) begin
                r_rej_sat <= 1'b1;
            end
        end
    end

endmodule
